encoder_pn_rr: RTL and testbench

- Parametrised N-to-log2(N) encoder with a registered output and a valid/ready handshake. It generalises the combinational 8-3 encoder.
- Two modes:
  - fixed priority: highest set index wins, so the N=8 results match the 8-3 truth table (D7 -> 111).
  - round-robin: a rotating pointer shares the grant fairly among simultaneous requests.
- Flags report an all-zero input and a multi-hot input.
- Sits between request sources and downstream consumers that need an index plus a handshake.

---
 rtl/encoder_pn_rr.sv | 131 +++++++++++++
 tb/tb_encoder_pn_rr.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_pn_rr.sv
// -----------------------------------------------------------------------------
// encoder_pn_rr
//   Parametrised N-to-log2(N) encoder. The result is held in a one-entry output
//   register and is passed on through a valid/ready handshake. Two grant modes:
//   fixed priority (the highest set index wins) and round-robin (a rotating
//   pointer shares the grant among simultaneous requests).
//
// Ports
//   iClk    in   1  clock, rising edge
//   iRst_n  in   1  asynchronous active-low reset
//   iValid  in   1  upstream vector present on iData
//   oReady  out  1  vector can be accepted this cycle
//   iData   in   N  request vector, bit k = line Dk
//   iMode   in   1  0 = fixed priority, 1 = round-robin
//   oValid  out  1  oData/oNone/oMulti hold a result
//   iReady  in   1  downstream consumes the result this cycle
//   oData   out  W  encoded index of the granted line
//   oNone   out  1  accepted vector was all zero
//   oMulti  out  1  accepted vector had more than one bit set
// -----------------------------------------------------------------------------
module encoder_pn_rr #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic         iValid,
    output logic         oReady,
    input  logic [N-1:0] iData,
    input  logic         iMode,
    output logic         oValid,
    input  logic         iReady,
    output logic [W-1:0] oData,
    output logic         oNone,
    output logic         oMulti
);

    localparam logic [W:0]   NW   = (W+1)'(N);
    localparam logic [W-1:0] NM1  = W'(N-1);
    localparam logic [N-1:0] ONE  = N'(1);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         r_none;
    logic         r_multi;
    logic [W-1:0] r_ptr;

    logic           w_accept;
    logic           w_none;
    logic           w_multi;
    logic [W-1:0]   w_fixed_idx;
    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [W-1:0]   w_off;
    logic [W:0]     w_sum;
    logic [W:0]     w_wrap;
    logic [W-1:0]   w_rr_idx;
    logic [W-1:0]   w_idx;
    logic [W-1:0]   w_ptr_next;

    assign oReady   = !r_valid || iReady;
    assign w_accept = iValid && oReady;

    assign w_none   = (iData == '0);
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_multi  = |(iData & (iData - ONE));

    // Fixed priority: later (higher) indices overwrite earlier ones.
    always_comb begin
        w_fixed_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (iData[k]) w_fixed_idx = W'(k);
        end
    end

    // Round-robin: rotate the request vector so that line r_ptr lands at bit 0,
    // find the lowest set bit there, then map the offset back modulo N.
    // Doubling the vector makes the rotation a plain right shift.
    assign w_dbl = {iData, iData} >> r_ptr;
    assign w_rot = w_dbl[N-1:0];

    always_comb begin
        w_off = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_rot[j]) w_off = W'(j);
        end
    end

    // r_ptr and w_off are both below N, so one conditional subtract suffices.
    assign w_sum    = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_wrap   = (w_sum >= NW) ? (w_sum - NW) : w_sum;
    assign w_rr_idx = w_wrap[W-1:0];

    always_comb begin
        w_idx = '0;
        if (!w_none) begin
            w_idx = iMode ? w_rr_idx : w_fixed_idx;
        end
    end

    // Wrap at N-1 rather than at 2^W-1 so unused codes are never reached.
    assign w_ptr_next = (w_idx == NM1) ? '0 : (w_idx + 1'b1);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_none  <= 1'b0;
            r_multi <= 1'b0;
            r_ptr   <= '0;
        end else begin
            if (w_accept) begin
                r_valid <= 1'b1;
                r_data  <= w_idx;
                r_none  <= w_none;
                r_multi <= w_multi;
                if (iMode && !w_none) begin
                    r_ptr <= w_ptr_next;
                end
            end else if (r_valid && iReady) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign oValid = r_valid;
    assign oData  = r_data;
    assign oNone  = r_none;
    assign oMulti = r_multi;

endmodule

// File: tb/tb_encoder_pn_rr.sv
// -----------------------------------------------------------------------------
// tb_encoder_pn_rr
//   Two instances: N=8 (power of two) and N=5 (non-power-of-two, W=3).
//   A reference model tracks the expected output register of each instance and
//   is compared against both on every falling clock edge; directed sequences
//   add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_encoder_pn_rr;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // N=8 instance
    logic       v8, r8, m8;
    logic [7:0] d8;
    logic       rdy8, ov8, none8, multi8;
    logic [2:0] od8;

    // N=5 instance
    logic       v5, r5, m5;
    logic [4:0] d5;
    logic       rdy5, ov5, none5, multi5;
    logic [2:0] od5;

    encoder_pn_rr #(.N(8)) dut8 (
        .iClk(clk), .iRst_n(rst_n), .iValid(v8), .oReady(rdy8), .iData(d8),
        .iMode(m8), .oValid(ov8), .iReady(r8), .oData(od8), .oNone(none8),
        .oMulti(multi8)
    );

    encoder_pn_rr #(.N(5)) dut5 (
        .iClk(clk), .iRst_n(rst_n), .iValid(v5), .oReady(rdy5), .iData(d5),
        .iMode(m5), .oValid(ov5), .iReady(r5), .oData(od5), .oNone(none5),
        .oMulti(multi5)
    );

    int n_chk = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // index 0 -> N=8 instance, index 1 -> N=5 instance
    logic ev [2] = '{1'b0, 1'b0};
    int   ed [2] = '{0, 0};
    logic en [2] = '{1'b0, 1'b0};
    logic em [2] = '{1'b0, 1'b0};
    int   ptr[2] = '{0, 0};

    task automatic model_step(input int i, input int n, input logic valid,
                              input logic [7:0] data, input logic mode,
                              input logic ird);
        int ones;
        int g;
        if (valid && (!ev[i] || ird)) begin
            ones = 0;
            for (int k = 0; k < n; k++) if (data[k]) ones++;
            g = 0;
            if (ones != 0) begin
                if (!mode) begin
                    for (int k = 0; k < n; k++) if (data[k]) g = k;
                end else begin
                    for (int s = n - 1; s >= 0; s--)
                        if (data[(ptr[i] + s) % n]) g = (ptr[i] + s) % n;
                    ptr[i] = (g + 1) % n;
                end
            end
            ev[i] = 1'b1;
            ed[i] = g;
            en[i] = (ones == 0);
            em[i] = (ones > 1);
        end else if (ev[i] && ird) begin
            ev[i] = 1'b0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                ev[i] = 1'b0; ed[i] = 0; en[i] = 1'b0; em[i] = 1'b0; ptr[i] = 0;
            end
        end else begin
            model_step(0, 8, v8, d8, m8, r8);
            model_step(1, 5, v5, {3'b000, d5}, m5, r5);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One compare process: every falling edge, both instances.
    always @(negedge clk) begin
        chk("n8.oValid", int'(ov8),    int'(ev[0]));
        chk("n8.oReady", int'(rdy8),   int'(!ev[0] || r8));
        chk("n8.oData",  int'(od8),    ed[0]);
        chk("n8.oNone",  int'(none8),  int'(en[0]));
        chk("n8.oMulti", int'(multi8), int'(em[0]));
        chk("n5.oValid", int'(ov5),    int'(ev[1]));
        chk("n5.oReady", int'(rdy5),   int'(!ev[1] || r5));
        chk("n5.oData",  int'(od5),    ed[1]);
        chk("n5.oNone",  int'(none5),  int'(en[1]));
        chk("n5.oMulti", int'(multi5), int'(em[1]));
    end

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] rr_pat;
        int         rr_exp[5];
        int         n5_exp[4];
        int         sel;

        rst_n = 1'b0;
        v8 = 0; r8 = 0; m8 = 0; d8 = '0;
        v5 = 0; r5 = 0; m5 = 0; d5 = '0;

        repeat (2) @(negedge clk);
        chk("rst.oValid", int'(ov8), 0);
        chk("rst.oData",  int'(od8), 0);
        chk("rst.oNone",  int'(none8), 0);
        chk("rst.oMulti", int'(multi8), 0);
        #2 rst_n = 1'b1;

        // Fixed-priority one-hot sweep, back-to-back
        cyc();
        v8 = 1; r8 = 1; m8 = 0;
        for (int k = 0; k < 8; k++) begin
            d8 = 8'(1 << k);
            cyc();
            chk("sweep.oValid", int'(ov8), 1);
            chk("sweep.oData",  int'(od8), k);
            chk("sweep.oNone",  int'(none8), 0);
            chk("sweep.oMulti", int'(multi8), 0);
        end

        // Flags
        d8 = 8'b0000_0000;
        cyc();
        chk("zero.oData", int'(od8), 0);
        chk("zero.oNone", int'(none8), 1);
        chk("zero.oMulti", int'(multi8), 0);
        d8 = 8'b1001_0110;
        cyc();
        chk("multi.oData", int'(od8), 7);
        chk("multi.oMulti", int'(multi8), 1);
        chk("multi.oNone", int'(none8), 0);

        // Round-robin fairness; pointer still 0 (fixed accepts hold it)
        rr_pat = 8'b1001_0110;
        rr_exp = '{1, 2, 4, 7, 1};
        m8 = 1; d8 = rr_pat;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("rr.oData", int'(od8), rr_exp[k]);
        end

        // Backpressure: accept 00100000, then stall 3 cycles
        m8 = 0; d8 = 8'b0010_0000;
        cyc();
        chk("bp.load", int'(od8), 5);
        r8 = 0;
        for (int k = 0; k < 3; k++) begin
            d8 = 8'($urandom);
            m8 = 1'($urandom);
            cyc();
            chk("bp.oValid", int'(ov8), 1);
            chk("bp.oData",  int'(od8), 5);
            chk("bp.oReady", int'(rdy8), 0);
        end
        // Transfer and accept together: no bubble
        r8 = 1; m8 = 0; d8 = 8'b0000_1000;
        cyc();
        chk("nobubble.oValid", int'(ov8), 1);
        chk("nobubble.oData",  int'(od8), 3);

        // Non-power-of-two N=5, round-robin
        v5 = 1; r5 = 1; m5 = 1; d5 = 5'b11001;
        n5_exp = '{0, 3, 4, 0};
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("n5.rr.oData", int'(od5), n5_exp[k]);
        end
        v5 = 0;

        // Drive the N=8 pointer to 3: RR grant of index 2. Last RR grant was 1, so ptr=2.
        m8 = 1; d8 = 8'b0000_0100;
        cyc();
        chk("ptr3.oData", int'(od8), 2);
        v8 = 0; r8 = 0;
        cyc();
        chk("stall.oValid", int'(ov8), 1);
        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        chk("async.oValid", int'(ov8), 0);
        chk("async.oData",  int'(od8), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        v8 = 1; m8 = 1; r8 = 1; d8 = 8'hFF;
        cyc();
        chk("post_rst.oData", int'(od8), 0);
        chk("post_rst.oMulti", int'(multi8), 1);

        // Randomized phase, both instances
        for (int c = 0; c < 3000; c++) begin
            v8 = 1'($urandom); r8 = ($urandom_range(0, 3) != 0); m8 = 1'($urandom);
            sel = $urandom_range(0, 3);
            d8 = (sel == 0) ? 8'h00 : (sel == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
            v5 = 1'($urandom); r5 = ($urandom_range(0, 3) != 0); m5 = 1'($urandom);
            sel = $urandom_range(0, 3);
            d5 = (sel == 0) ? 5'h00 : (sel == 1) ? 5'(1 << $urandom_range(0, 4)) : 5'($urandom);
            if (c == 1500) begin
                // occasional mid-run asynchronous reset
                #3 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            cyc();
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
